// File: rtl/id_ex_skid_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_skid_stage
//  Description : ID/EX pipeline register with a valid/ready handshake and a
//                2-entry skid buffer (main register + one skid entry).
//                Splits the EX control field into RegDst / ALUOp / ALUSrc,
//                supports flush (NOP bubble insertion) and counts stall
//                cycles with a saturating counter.
//  Ports       : clk_IDEX / rst_IDEX        clock, sync active-high reset
//                in_valid / in_ready        upstream handshake (decode)
//                out_valid / out_ready      downstream handshake (EX)
//                flush                      drop all held and incoming payloads
//                *_IN                       payload from decode
//                nextInst..WB, RegDst,      registered payload to EX
//                ALUOp, ALUSrc
//                stall_cnt                  saturating back-pressure counter
//  Revision    : 1.0  initial release
// ============================================================================
module id_ex_skid_stage #(
    parameter int DATA_W  = 32,
    parameter int PC_W    = 8,
    parameter int REG_W   = 5,
    parameter int M_W     = 3,
    parameter int WB_W    = 2,
    parameter int ALUOP_W = 2,
    parameter int CNT_W   = 16,
    parameter int EX_W    = ALUOP_W + 2
) (
    input  logic               clk_IDEX,
    input  logic               rst_IDEX,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    input  logic [PC_W-1:0]    nextInst_IN,
    input  logic [DATA_W-1:0]  regData1_IN,
    input  logic [DATA_W-1:0]  regData2_IN,
    input  logic [DATA_W-1:0]  rdshfunct_IN,
    input  logic [REG_W-1:0]   rd_IN,
    input  logic [REG_W-1:0]   rt_IN,
    input  logic [M_W-1:0]     M_IN,
    input  logic [EX_W-1:0]    EX_IN,
    input  logic [WB_W-1:0]    WB_IN,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    nextInst,
    output logic [DATA_W-1:0]  regData1,
    output logic [DATA_W-1:0]  regData2,
    output logic [DATA_W-1:0]  rdshfunct,
    output logic [REG_W-1:0]   rd,
    output logic [REG_W-1:0]   rt,
    output logic [M_W-1:0]     M,
    output logic [WB_W-1:0]    WB,
    output logic               RegDst,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               ALUSrc,
    output logic [CNT_W-1:0]   stall_cnt
);

    // Payload packing: control fields occupy the low bits so a flush can
    // zero them with a single slice while the data fields keep their values.
    localparam int WB_LO  = 0;
    localparam int EX_LO  = WB_LO + WB_W;
    localparam int M_LO   = EX_LO + EX_W;
    localparam int CTL_W  = M_LO + M_W;
    localparam int RT_LO  = CTL_W;
    localparam int RD_LO  = RT_LO + REG_W;
    localparam int IMM_LO = RD_LO + REG_W;
    localparam int R2_LO  = IMM_LO + DATA_W;
    localparam int R1_LO  = R2_LO + DATA_W;
    localparam int PC_LO  = R1_LO + DATA_W;
    localparam int PAY_W  = PC_LO + PC_W;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t             state;
    logic [PAY_W-1:0]   main_pay;
    logic [PAY_W-1:0]   skid_pay;
    logic [PAY_W-1:0]   in_pay;
    logic               accept;
    logic               drain;
    logic               load_main;
    logic               load_skid;

    assign in_pay = {nextInst_IN, regData1_IN, regData2_IN, rdshfunct_IN,
                     rd_IN, rt_IN, M_IN, EX_IN, WB_IN};

    // Skid entry is only occupied in TWO; readiness drops during reset.
    assign in_ready  = (state != TWO) && !rst_IDEX;
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    // Main register loads whenever its current content leaves (or it is
    // empty) and something is available; in TWO the source is the skid.
    assign load_main = ((state == EMPTY) && accept) ||
                       ((state == ONE)   && accept && drain) ||
                       ((state == TWO)   && drain);
    assign load_skid = (state == ONE) && accept && !drain;

    always_ff @(posedge clk_IDEX) begin
        if (rst_IDEX) begin
            state     <= EMPTY;
            main_pay  <= '0;
            skid_pay  <= '0;
            stall_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != CNT_MAX))
                stall_cnt <= stall_cnt + CNT_W'(1);

            if (flush) begin
                state                <= EMPTY;
                skid_pay             <= '0;
                main_pay[CTL_W-1:0]  <= '0;
            end else begin
                case (state)
                    EMPTY:   if (accept) state <= ONE;
                    ONE: begin
                        if (accept && !drain)      state <= TWO;
                        else if (!accept && drain) state <= EMPTY;
                    end
                    TWO:     if (drain) state <= ONE;
                    default: state <= EMPTY;
                endcase

                if (load_main)
                    main_pay <= (state == TWO) ? skid_pay : in_pay;
                if (load_skid)
                    skid_pay <= in_pay;
            end
        end
    end

    assign nextInst  = main_pay[PC_LO  +: PC_W];
    assign regData1  = main_pay[R1_LO  +: DATA_W];
    assign regData2  = main_pay[R2_LO  +: DATA_W];
    assign rdshfunct = main_pay[IMM_LO +: DATA_W];
    assign rd        = main_pay[RD_LO  +: REG_W];
    assign rt        = main_pay[RT_LO  +: REG_W];
    assign M         = main_pay[M_LO   +: M_W];
    assign WB        = main_pay[WB_LO  +: WB_W];
    assign RegDst    = main_pay[EX_LO + EX_W - 1];
    assign ALUOp     = main_pay[EX_LO + 1 +: ALUOP_W];
    assign ALUSrc    = main_pay[EX_LO];

endmodule
`default_nettype wire

// File: tb/tb_id_ex_skid_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_skid_stage
//  Description : Self-checking bench for id_ex_skid_stage. A queue-based
//                model (at most two payloads in flight, head is visible)
//                predicts every output each cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_id_ex_skid_stage;

    typedef struct packed {
        logic [7:0]  pc;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rt;
        logic [2:0]  m;
        logic [3:0]  ex;
        logic [1:0]  wb;
    } pay_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        flush = 1'b0;
    pay_t        din = '0;

    logic        in_ready, out_valid;
    logic [7:0]  nextInst;
    logic [31:0] regData1, regData2, rdshfunct;
    logic [4:0]  rd, rt;
    logic [2:0]  M;
    logic [1:0]  WB;
    logic        RegDst, ALUSrc;
    logic [1:0]  ALUOp;
    logic [3:0]  stall_cnt;

    always #5 clk = ~clk;

    id_ex_skid_stage #(.CNT_W(4)) dut (
        .clk_IDEX(clk), .rst_IDEX(rst),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .nextInst_IN(din.pc), .regData1_IN(din.r1), .regData2_IN(din.r2),
        .rdshfunct_IN(din.imm), .rd_IN(din.rd), .rt_IN(din.rt),
        .M_IN(din.m), .EX_IN(din.ex), .WB_IN(din.wb),
        .out_valid(out_valid), .out_ready(out_ready),
        .nextInst(nextInst), .regData1(regData1), .regData2(regData2),
        .rdshfunct(rdshfunct), .rd(rd), .rt(rt), .M(M), .WB(WB),
        .RegDst(RegDst), .ALUOp(ALUOp), .ALUSrc(ALUSrc),
        .stall_cnt(stall_cnt)
    );

    // Reference model: FIFO of accepted payloads (capacity 2); "shown" is
    // what the output fields display, including after the FIFO empties.
    pay_t q[$];
    pay_t shown = '0;
    int   cnt = 0;
    int   n_pass = 0;
    int   n_total = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit ov, ir, acc, drn;
        if (rst) begin
            q.delete();
            shown = '0;
            cnt = 0;
        end else begin
            ov = (q.size() > 0);
            ir = (q.size() < 2);
            if (ov && !out_ready && cnt < 15) cnt++;
            if (flush) begin
                q.delete();
                shown.m  = '0;
                shown.ex = '0;
                shown.wb = '0;
            end else begin
                acc = in_valid && ir;
                drn = ov && out_ready;
                if (drn) void'(q.pop_front());
                if (acc) q.push_back(din);
                if (q.size() > 0) shown = q[0];
            end
        end
    endtask

    task automatic cycle();
        pay_t obs;
        @(posedge clk);
        model_step();
        @(negedge clk);
        obs = '{pc: nextInst, r1: regData1, r2: regData2, imm: rdshfunct,
                rd: rd, rt: rt, m: M, ex: {RegDst, ALUOp, ALUSrc}, wb: WB};
        chk("out_valid", 256'(out_valid), 256'(q.size() > 0));
        chk("in_ready",  256'(in_ready),  256'((q.size() < 2) && !rst));
        chk("payload",   256'(obs),       256'(shown));
        chk("stall_cnt", 256'(stall_cnt), 256'(cnt));
    endtask

    function automatic pay_t rand_pay();
        pay_t p;
        p.pc  = 8'($urandom);
        p.r1  = $urandom;
        p.r2  = $urandom;
        p.imm = $urandom;
        p.rd  = 5'($urandom);
        p.rt  = 5'($urandom);
        p.m   = 3'($urandom);
        p.ex  = 4'($urandom);
        p.wb  = 2'($urandom);
        return p;
    endfunction

    initial begin
        // Reset held two cycles with a payload offered.
        rst = 1'b1; in_valid = 1'b1; din = rand_pay();
        cycle(); cycle();

        // Streaming: four back-to-back payloads, EX = {RegDst=1, ALUOp=10, ALUSrc=1}.
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            din = rand_pay(); din.r1 = 32'(i); din.ex = 4'b1101;
            in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        cycle(); cycle();

        // Back-pressure: A and B fill both entries, C is refused.
        out_ready = 1'b0;
        in_valid = 1'b1; din = rand_pay(); cycle();
        din = rand_pay(); cycle();
        din = rand_pay();
        for (int i = 0; i < 3; i++) cycle();
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        // Flush in TWO while C is offered.
        out_ready = 1'b0;
        in_valid = 1'b1; din = rand_pay(); cycle();
        din = rand_pay(); cycle();
        din = rand_pay(); flush = 1'b1; cycle();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cycle(); cycle();

        // Saturation: one payload stalled 20 cycles.
        out_ready = 1'b0;
        in_valid = 1'b1; din = rand_pay(); cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) cycle();
        out_ready = 1'b1; cycle(); cycle();

        // Reset while in TWO: held payloads must never come out.
        out_ready = 1'b0;
        in_valid = 1'b1; din = rand_pay(); cycle();
        din = rand_pay(); cycle();
        in_valid = 1'b0; rst = 1'b1; cycle();
        rst = 1'b0; out_ready = 1'b1;
        cycle(); cycle(); cycle();

        // Randomized traffic with occasional flush.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 55);
            flush     = ($urandom_range(0, 99) < 4);
            din       = rand_pay();
            cycle();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cycle(); cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
